// File: rtl/awgn_gen_multi_if.sv
// rtl/awgn_gen_multi_if.sv - control and sample bus of the multi-channel AWGN source
interface awgn_gen_multi_if #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int DIV_WIDTH = 16
);
  logic                      enable;
  logic [DIV_WIDTH-1:0]      rate_div;
  logic                      seed_load;
  logic [31:0]               seed;
  logic signed [WIDTH-1:0]   mean;
  logic [7:0]                var_scale;
  logic [CHANNELS*WIDTH-1:0] noise_out;
  logic                      noise_valid;
  logic [CHANNELS-1:0]       sat_flag;
  logic                      sample_clk;
  logic                      overrun;

  modport master (
    output enable, rate_div, seed_load, seed, mean, var_scale,
    input  noise_out, noise_valid, sat_flag, sample_clk, overrun
  );

  modport slave (
    input  enable, rate_div, seed_load, seed, mean, var_scale,
    output noise_out, noise_valid, sat_flag, sample_clk, overrun
  );
endinterface

// File: rtl/awgn_gen_multi.sv
// rtl/awgn_gen_multi.sv - multi-channel CLT noise source: per-channel LFSR, averaging,
// Q4.4 gain, mean offset and saturation at a divided sample rate
module awgn_gen_multi #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int CLT_TERMS = 4,
  parameter int DIV_WIDTH = 16
) (
  input logic            MCLK,
  input logic            n_reset,
  awgn_gen_multi_if.slave bus
);
  localparam int LOG2 = $clog2(CLT_TERMS);
  localparam int ACCW = WIDTH + LOG2;
  localparam int PW   = WIDTH + 9;
  localparam int YW   = WIDTH + 10;
  localparam int TW   = LOG2 + 1;
  localparam int USH  = (WIDTH < 16) ? (16 - WIDTH) : 0;
  localparam logic [31:0] LFSR_MASK  = 32'h80200003;
  localparam logic [31:0] GOLDEN     = 32'h9E3779B9;
  localparam logic [31:0] RESET_BASE = 32'hACE12468;
  localparam logic signed [YW-1:0] Y_MAX = {{(YW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [YW-1:0] Y_MIN = {{(YW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int k);
    logic [31:0] s;
    s = base ^ (GOLDEN * 32'(k));
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  // Top LFSR half with inverted MSB gives a zero-mean signed uniform.
  function automatic logic signed [WIDTH-1:0] uniform(input logic [31:0] s);
    logic signed [15:0] u;
    u = {~s[31], s[30:16]};
    if (WIDTH >= 16) return WIDTH'(u);
    else             return WIDTH'(u >>> USH);
  endfunction

  state_t                    state_q, state_d;
  logic [DIV_WIDTH-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]             term_q, term_d;
  logic [31:0]               lfsr_q [CHANNELS];
  logic [31:0]               lfsr_d [CHANNELS];
  logic signed [ACCW-1:0]    acc_q  [CHANNELS];
  logic signed [ACCW-1:0]    acc_d  [CHANNELS];
  logic signed [PW-1:0]      prod_q [CHANNELS];
  logic signed [PW-1:0]      prod_d [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] noise_q, noise_d;
  logic [CHANNELS-1:0]       sat_q, sat_d;
  logic                      valid_q, valid_d;
  logic                      sclk_q, sclk_d;
  logic                      ovr_q, ovr_d;
  logic                      run, tick;

  assign run  = bus.enable && !bus.seed_load;
  assign tick = run && (cnt_q == bus.rate_div);

  always_ff @(posedge MCLK or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (tick) state_d = ACCUM;
        ACCUM:   if (term_q == TW'(CLT_TERMS - 1)) state_d = SCALE;
        SCALE:   state_d = OUT;
        OUT:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Rate counter, LFSRs, sample clock and overrun run independently of the FSM.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    ovr_d  = ovr_q;
    for (int k = 0; k < CHANNELS; k++) lfsr_d[k] = lfsr_q[k];
    if (bus.seed_load) begin
      cnt_d = '0;
      ovr_d = 1'b0;
      for (int k = 0; k < CHANNELS; k++) lfsr_d[k] = chan_seed(bus.seed, k);
    end else if (bus.enable) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
      if (tick) sclk_d = ~sclk_q;
      if (tick && state_q != IDLE) ovr_d = 1'b1;
      for (int k = 0; k < CHANNELS; k++)
        lfsr_d[k] = {1'b0, lfsr_q[k][31:1]} ^ (lfsr_q[k][0] ? LFSR_MASK : 32'd0);
    end
  end

  always_comb begin
    logic signed [ACCW-1:0]  avg_full;
    logic signed [WIDTH-1:0] avg_w;
    logic signed [PW-1:0]    shifted;
    logic signed [YW-1:0]    yv;
    avg_full = '0;
    avg_w    = '0;
    shifted  = '0;
    yv       = '0;
    term_d   = term_q;
    valid_d  = 1'b0;
    noise_d  = noise_q;
    sat_d    = sat_q;
    for (int k = 0; k < CHANNELS; k++) begin
      acc_d[k]  = acc_q[k];
      prod_d[k] = prod_q[k];
    end
    case (state_q)
      IDLE: if (tick) begin
        term_d = '0;
        for (int k = 0; k < CHANNELS; k++) acc_d[k] = '0;
      end
      ACCUM: if (run) begin
        term_d = term_q + TW'(1);
        for (int k = 0; k < CHANNELS; k++)
          acc_d[k] = acc_q[k] + ACCW'(uniform(lfsr_q[k]));
      end
      SCALE: if (run) begin
        for (int k = 0; k < CHANNELS; k++) begin
          avg_full  = acc_q[k] >>> LOG2;
          avg_w     = WIDTH'(avg_full);
          prod_d[k] = PW'(avg_w) * PW'($signed({1'b0, bus.var_scale}));
        end
      end
      OUT: if (run) begin
        valid_d = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
          shifted = prod_q[k] >>> 4;
          yv      = YW'(shifted) + YW'(bus.mean);
          if (yv > Y_MAX) begin
            noise_d[k*WIDTH +: WIDTH] = Y_MAX[WIDTH-1:0];
            sat_d[k] = 1'b1;
          end else if (yv < Y_MIN) begin
            noise_d[k*WIDTH +: WIDTH] = Y_MIN[WIDTH-1:0];
            sat_d[k] = 1'b1;
          end else begin
            noise_d[k*WIDTH +: WIDTH] = yv[WIDTH-1:0];
            sat_d[k] = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCLK or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q   <= '0;
      term_q  <= '0;
      noise_q <= '0;
      sat_q   <= '0;
      valid_q <= 1'b0;
      sclk_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        lfsr_q[k] <= chan_seed(RESET_BASE, k);
        acc_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      noise_q <= noise_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      sclk_q  <= sclk_d;
      ovr_q   <= ovr_d;
      for (int k = 0; k < CHANNELS; k++) begin
        lfsr_q[k] <= lfsr_d[k];
        acc_q[k]  <= acc_d[k];
        prod_q[k] <= prod_d[k];
      end
    end
  end

  assign bus.noise_out   = noise_q;
  assign bus.noise_valid = valid_q;
  assign bus.sat_flag    = sat_q;
  assign bus.sample_clk  = sclk_q;
  assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_awgn_gen_multi.sv
// tb/tb_awgn_gen_multi.sv - directed bench for awgn_gen_multi (WIDTH 16, 2 channels, 4 terms)
module tb_awgn_gen_multi;
  logic MCLK = 1'b0;
  logic n_reset = 1'b0;
  int   cyc = 0;
  int   cyc_s = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic sclk_prev = 1'b0;

  int          v_cyc  [$];
  logic [31:0] v_data [$];
  logic [1:0]  v_sat  [$];
  int          sc_cyc [$];
  logic [31:0] cap0   [$];

  awgn_gen_multi_if #(.WIDTH(16), .CHANNELS(2), .DIV_WIDTH(16)) bus ();

  awgn_gen_multi #(.WIDTH(16), .CHANNELS(2), .CLT_TERMS(4), .DIV_WIDTH(16)) dut (
    .MCLK    (MCLK),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc <= cyc + 1;

  always @(negedge MCLK) begin
    if (bus.noise_valid) begin
      v_cyc.push_back(cyc);
      v_data.push_back(bus.noise_out);
      v_sat.push_back(bus.sat_flag);
    end
    if (bus.sample_clk != sclk_prev) sc_cyc.push_back(cyc);
    sclk_prev = bus.sample_clk;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] cseed(input logic [31:0] b, input int k);
    logic [31:0] s;
    s = b ^ (32'h9E3779B9 * 32'(k));
    return (s == 0) ? 32'd1 : s;
  endfunction

  function automatic int uni(input logic [31:0] s);
    logic signed [15:0] u;
    u = {~s[31], s[30:16]};
    return int'(u);
  endfunction

  // Sample n uses the LFSR states of the four cycles following its tick cycle.
  task automatic model(input logic [31:0] base, input int k, input int n, input int r,
                       input int vs, input int mean, output int y, output bit sat);
    logic [31:0] s;
    int sum, avg, p, t;
    s = cseed(base, k);
    for (int i = 0; i < r + n * (r + 1) + 1; i++) s = step(s);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      sum += uni(s);
      s = step(s);
    end
    avg = sum >>> 2;
    p   = avg * vs;
    t   = (p >>> 4) + mean;
    sat = 1'b0;
    y   = t;
    if (t > 32767)       begin y = 32767;  sat = 1'b1; end
    else if (t < -32768) begin y = -32768; sat = 1'b1; end
  endtask

  task automatic do_seed(input logic [31:0] s, input int r, input int vs, input int m);
    @(negedge MCLK);
    bus.seed      = s;
    bus.rate_div  = 16'(r);
    bus.var_scale = 8'(vs);
    bus.mean      = 16'(m);
    bus.seed_load = 1'b1;
    bus.enable    = 1'b1;
    @(negedge MCLK);
    bus.seed_load = 1'b0;
    cyc_s = cyc;
    v_cyc.delete();
    v_data.delete();
    v_sat.delete();
    sc_cyc.delete();
  endtask

  task automatic wait_valids(input int n, input string tag);
    int budget;
    budget = n * 200 + 300;
    while (v_cyc.size() < n && budget > 0) begin
      @(negedge MCLK);
      budget--;
    end
    #1;
    check(tag, v_cyc.size() >= n, 1);
  endtask

  task automatic check_run(input logic [31:0] base, input int r, input int vs,
                           input int mean, input int n, input string tag);
    int y;
    bit sat;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        model(base, k, i, r, vs, mean, y, sat);
        check($sformatf("%s_v%0d_c%0d", tag, i, k), $signed(v_data[i][k*16 +: 16]), y);
        check($sformatf("%s_sat%0d_c%0d", tag, i, k), v_sat[i][k], sat);
      end
    end
  endtask

  initial begin
    int diff, mism;
    logic [31:0] hold;
    bus.enable = 1'b0; bus.rate_div = '0; bus.seed_load = 1'b0;
    bus.seed = '0; bus.mean = '0; bus.var_scale = '0;

    repeat (10) @(negedge MCLK);
    check("rst_noise", bus.noise_out, 0);
    check("rst_valid", bus.noise_valid, 0);
    check("rst_sat", bus.sat_flag, 0);
    check("rst_sclk", bus.sample_clk, 0);
    check("rst_ovr", bus.overrun, 0);
    n_reset = 1'b1;
    repeat (100) @(negedge MCLK);
    #1;
    check("idle_noise", bus.noise_out, 0);
    check("idle_valids", v_cyc.size(), 0);
    check("idle_sclk", sc_cyc.size(), 0);

    do_seed(32'h12345678, 99, 0, 1000);
    repeat (350) @(negedge MCLK);
    #1;
    check("zg_count", v_cyc.size(), 3);
    check("zg_first", v_cyc[0] - cyc_s, 106);
    check("zg_spacing", v_cyc[1] - v_cyc[0], 100);
    check("zg_spacing2", v_cyc[2] - v_cyc[1], 100);
    check("sclk_first", sc_cyc[0] - cyc_s, 100);
    check("sclk_half", sc_cyc[1] - sc_cyc[0], 100);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 2; k++)
        check($sformatf("zg_v%0d_c%0d", i, k), $signed(v_data[i][k*16 +: 16]), 1000);
    check("zg_ovr", bus.overrun, 0);

    do_seed(32'h12345678, 6, 16, 0);
    wait_valids(64, "mod_wait");
    check_run(32'h12345678, 6, 16, 0, 64, "mod");
    check("mod_ovr", bus.overrun, 0);
    diff = 0;
    cap0 = v_data;
    for (int i = 0; i < 64; i++) diff += int'(v_data[i][15:0] != v_data[i][31:16]);
    check("ch_differ", diff > 0, 1);
    do_seed(32'h12345678, 6, 16, 0);
    wait_valids(64, "rep_wait");
    mism = 0;
    for (int i = 0; i < 64; i++) mism += int'(v_data[i] != cap0[i]);
    check("repro", mism, 0);

    do_seed(32'h00000000, 6, 16, 0);
    wait_valids(4, "z_wait");
    check_run(32'h00000000, 6, 16, 0, 4, "zseed");

    do_seed(32'hCAFEF00D, 6, 255, 32767);
    wait_valids(16, "satp_wait");
    check_run(32'hCAFEF00D, 6, 255, 32767, 16, "satp");
    do_seed(32'hCAFEF00D, 6, 255, -32768);
    wait_valids(16, "satn_wait");
    check_run(32'hCAFEF00D, 6, 255, -32768, 16, "satn");

    do_seed(32'h0BADBEEF, 2, 16, 0);
    check("ovr_start", bus.overrun, 0);
    repeat (5) @(negedge MCLK);
    check("ovr_first_tick", bus.overrun, 0);
    @(negedge MCLK);
    check("ovr_second_tick", bus.overrun, 1);
    repeat (30) @(negedge MCLK);
    check("ovr_sticky", bus.overrun, 1);
    do_seed(32'h0BADBEEF, 6, 16, 0);
    check("ovr_cleared", bus.overrun, 0);

    repeat (9) @(negedge MCLK);
    bus.enable = 1'b0;
    hold = bus.noise_out;
    repeat (20) @(negedge MCLK);
    #1;
    check("abort_valids", v_cyc.size(), 0);
    check("abort_hold", bus.noise_out, hold);
    check("abort_sclk", sc_cyc.size(), 1);

    do_seed(32'h0BADBEEF, 6, 16, 0);
    wait_valids(2, "mid_wait");
    repeat (3) @(negedge MCLK);
    #2;
    n_reset = 1'b0;
    #1;
    check("mid_rst_noise", bus.noise_out, 0);
    check("mid_rst_valid", bus.noise_valid, 0);
    check("mid_rst_sat", bus.sat_flag, 0);
    check("mid_rst_ovr", bus.overrun, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
